victim_cache: RTL and testbench
===============================

VICTIM_CACHE -- requirements
Module: victim_cache

Interface
REQ-001 Parameter VC_ENTRIES, 4, number of fully associative entries (power of two, 2..16).
REQ-002 Parameter LINE_ADDR_W, 28, cache-line address width.
REQ-003 Parameter LINE_W, 128, cache-line data width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 lookup_req_i  in  1  dcache miss-probe request.
REQ-008 lookup_addr_i  in  LINE_ADDR_W  line address probed.
REQ-009 victim_hit_o  out  1  probe hit, valid one cycle after request.
REQ-010 vc_line_o / vc_line_dirty_o  out  LINE_W / 1  data and dirty bit of hit entry.
REQ-011 write_from_victim_i  in  1  dcache takes hit line; entry is invalidated.
REQ-012 write_to_victim_i  in  1  dcache pushes an evicted line.
REQ-013 evict_addr_i / evict_line_i / evict_dirty_i  in  LINE_ADDR_W / LINE_W / 1  evicted line.
REQ-014 vc_ready_o  out  1  block can accept write_to_victim_i this cycle.
REQ-015 vc2mem_req_o / vc2mem_addr_o / vc2mem_line_o  out  1 / LINE_ADDR_W / LINE_W  dirty write-back to memory.
REQ-016 mem2vc_ack_i  in  1  memory accepted write-back.
REQ-017 vc_flush_i  in  1  flush request; vc_flush_done_o  out  1  one-cycle completion pulse.

Function
REQ-018 Per entry: valid, dirty, address, line; replacement pointer rp (log2 VC_ENTRIES bits); write-back buffer (addr, line).
REQ-019 Lookup: lookup_req_i in cycle N compares lookup_addr_i to all valid entries; victim_hit_o asserted in N+1 for one cycle only on match; hit index registered.
REQ-020 vc_line_o/vc_line_dirty_o SHALL show the hit entry in N+1 and hold until the next lookup; value on miss is don't-care.
REQ-021 write_from_victim_i while victim_hit_o high clears that entry's valid at the next edge; ignored when victim_hit_o low.
REQ-022 Insert (write_to_victim_i && vc_ready_o): target = valid entry with equal address if any; else lowest-index invalid entry; else entry rp, then rp increments modulo VC_ENTRIES.
REQ-023 rp SHALL advance only on replacement of a valid entry; wrap from VC_ENTRIES-1 to 0.
REQ-024 Replaced valid dirty entry (non-matching address) SHALL be copied to the write-back buffer and FSM enters VC_WB; clean entries are silently overwritten.
REQ-025 Same-cycle write_from_victim_i (accepted) and write_to_victim_i: insertion targets the freed hit entry (swap); no write-back, rp unchanged.
REQ-026 FSM states: VC_IDLE, VC_WB, VC_FLUSH_SCAN, VC_FLUSH_WB, VC_FLUSH_DONE.
REQ-027 VC_WB: vc2mem_req_o high with buffer contents from the cycle after entry until the cycle mem2vc_ack_i is sampled high, then VC_IDLE (or VC_FLUSH_SCAN if flush pending).
REQ-028 vc_ready_o = 1 only in VC_IDLE; write_to_victim_i with vc_ready_o low SHALL be ignored (protocol violation, asserted in bench).
REQ-029 Lookups and write_from_victim_i SHALL be serviced in VC_IDLE and VC_WB.
REQ-030 vc_flush_i in VC_IDLE enters VC_FLUSH_SCAN; in VC_WB it is latched and acted on after ack.
REQ-031 VC_FLUSH_SCAN: scan index 0..VC_ENTRIES-1, one entry per cycle; valid dirty entry -> load buffer, go VC_FLUSH_WB (same handshake as REQ-027), return to scan at index+1; every scanned entry invalidated.
REQ-032 After last index, VC_FLUSH_DONE: vc_flush_done_o high one cycle, rp cleared, return VC_IDLE.
REQ-033 During flush states victim_hit_o SHALL be 0 and lookups ignored.
REQ-034 At most one write-back outstanding; vc2mem_addr_o/vc2mem_line_o stable while vc2mem_req_o high.

Reset
REQ-035 rst asserted: all valid/dirty cleared, rp=0, FSM VC_IDLE, victim_hit_o=0, vc2mem_req_o=0, vc_flush_done_o=0, vc_ready_o=1 after release, vc_line_o=0.
REQ-036 Reset mid write-back or flush SHALL drop the request immediately; buffered data is lost.

Verification
REQ-037 Push addr 0x10 clean, lookup 0x10 -> victim_hit_o=1 next cycle, vc_line_o = pushed line; lookup 0x11 -> victim_hit_o=0.
REQ-038 Fill 4 entries (one dirty at entry 0), push 5th -> entry 0 replaced, rp=1, vc2mem_req_o held with entry-0 data until ack; vc_ready_o low meanwhile.
REQ-039 Hit 0x20, assert write_from_victim_i with write_to_victim_i (0x30) same cycle -> 0x30 occupies former 0x20 slot, no write-back, lookup 0x20 misses.
REQ-040 Two dirty + two clean entries, vc_flush_i -> exactly two write-backs in index order, vc_flush_done_o pulse, all lookups miss afterwards.
REQ-041 Assert rst while vc2mem_req_o high -> vc2mem_req_o low asynchronously, all lookups miss after release.
REQ-042 Push address already present with new data -> single entry updated, no duplicate hit, rp unchanged.

Source files
------------

// File: rtl/victim_cache.sv
// Victim cache: small fully associative store for lines evicted from the dcache.
// It holds one write-back buffer for dirty lines that are displaced or flushed.
// A single FSM sequences write-backs and the entry-by-entry flush scan.

module vc_tag_cmp #(
  parameter int LINE_ADDR_W = 28
) (
  input  logic                   valid,
  input  logic [LINE_ADDR_W-1:0] tag,
  input  logic [LINE_ADDR_W-1:0] lookup_addr,
  input  logic [LINE_ADDR_W-1:0] evict_addr,
  output logic                   lookup_match,
  output logic                   evict_match
);
  assign lookup_match = valid && (tag == lookup_addr);
  assign evict_match  = valid && (tag == evict_addr);
endmodule

module victim_cache #(
  parameter int VC_ENTRIES  = 4,
  parameter int LINE_ADDR_W = 28,
  parameter int LINE_W      = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  output logic                   victim_hit_o,
  output logic [LINE_W-1:0]      vc_line_o,
  output logic                   vc_line_dirty_o,
  input  logic                   write_from_victim_i,
  input  logic                   write_to_victim_i,
  input  logic [LINE_ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0]      evict_line_i,
  input  logic                   evict_dirty_i,
  output logic                   vc_ready_o,
  output logic                   vc2mem_req_o,
  output logic [LINE_ADDR_W-1:0] vc2mem_addr_o,
  output logic [LINE_W-1:0]      vc2mem_line_o,
  input  logic                   mem2vc_ack_i,
  input  logic                   vc_flush_i,
  output logic                   vc_flush_done_o
);
  localparam int IDX_W = $clog2(VC_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_ENTRIES - 1);

  typedef enum logic [2:0] {
    VC_IDLE, VC_WB, VC_FLUSH_SCAN, VC_FLUSH_WB, VC_FLUSH_DONE
  } vc_state_e;

  vc_state_e state;

  logic [VC_ENTRIES-1:0]                  valid, dirty;
  logic [VC_ENTRIES-1:0][LINE_ADDR_W-1:0] tag;
  logic [VC_ENTRIES-1:0][LINE_W-1:0]      line;
  logic [IDX_W-1:0]                       rp, hit_idx, scan_idx;
  logic                                   flush_pend;
  logic [LINE_ADDR_W-1:0]                 wb_addr;
  logic [LINE_W-1:0]                      wb_line;

  logic [VC_ENTRIES-1:0] lk_match, ev_match;
  logic                  lk_any, ev_any, inv_any;
  logic [IDX_W-1:0]      lk_idx, ev_idx, inv_idx;
  logic [IDX_W-1:0]      ins_idx, wb_src;
  logic                  ins_spill, ins_adv;
  logic                  in_service, take, ins, spill, scan_hit, flush_next, lookup_ok;

  // One comparator per entry, checked against both the probe and the incoming line.
  for (genvar g = 0; g < VC_ENTRIES; g++) begin : g_cmp
    vc_tag_cmp #(.LINE_ADDR_W(LINE_ADDR_W)) u_cmp (
      .valid        (valid[g]),
      .tag          (tag[g]),
      .lookup_addr  (lookup_addr_i),
      .evict_addr   (evict_addr_i),
      .lookup_match (lk_match[g]),
      .evict_match  (ev_match[g])
    );
  end

  assign in_service = (state == VC_IDLE) || (state == VC_WB);
  assign vc_ready_o = (state == VC_IDLE);
  assign take       = write_from_victim_i && victim_hit_o && in_service;
  assign ins        = write_to_victim_i && (state == VC_IDLE);
  assign spill      = ins && ins_spill;
  assign scan_hit   = (state == VC_FLUSH_SCAN) && valid[scan_idx] && dirty[scan_idx];
  assign wb_src     = (state == VC_FLUSH_SCAN) ? scan_idx : rp;

  // A probe landing on the cycle we head into a flush would otherwise report
  // a hit while the flush is running, so it is dropped.
  assign flush_next = ((state == VC_IDLE) && vc_flush_i) ||
                      ((state == VC_WB) && mem2vc_ack_i && (flush_pend || vc_flush_i));
  assign lookup_ok  = lookup_req_i && in_service && !flush_next;

  assign vc2mem_addr_o = wb_addr;
  assign vc2mem_line_o = wb_line;

  // Lowest-index priority encoders for probe hit, same-address entry and free slot.
  always_comb begin
    lk_any  = 1'b0;
    lk_idx  = '0;
    ev_any  = 1'b0;
    ev_idx  = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) begin lk_any = 1'b1; lk_idx = IDX_W'(i); end
      if (ev_match[i]) begin ev_any = 1'b1; ev_idx = IDX_W'(i); end
      if (!valid[i])   begin inv_any = 1'b1; inv_idx = IDX_W'(i); end
    end
  end

  // Insert target: swap slot, else same-address entry, else free slot, else round-robin victim.
  always_comb begin
    ins_idx   = rp;
    ins_spill = 1'b0;
    ins_adv   = 1'b0;
    if (take)         ins_idx = hit_idx;
    else if (ev_any)  ins_idx = ev_idx;
    else if (inv_any) ins_idx = inv_idx;
    else begin
      ins_adv   = 1'b1;
      ins_spill = dirty[rp];
    end
  end

  // Line storage and write-back buffer; contents are meaningless until marked valid.
  always_ff @(posedge clk) begin
    if (ins) begin
      tag[ins_idx]  <= evict_addr_i;
      line[ins_idx] <= evict_line_i;
    end
    if (spill || scan_hit) begin
      wb_addr <= tag[wb_src];
      wb_line <= line[wb_src];
    end
  end

  // Control FSM with entry status, probe result and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= VC_IDLE;
      valid           <= '0;
      dirty           <= '0;
      rp              <= '0;
      hit_idx         <= '0;
      scan_idx        <= '0;
      flush_pend      <= 1'b0;
      victim_hit_o    <= 1'b0;
      vc_line_o       <= '0;
      vc_line_dirty_o <= 1'b0;
      vc2mem_req_o    <= 1'b0;
      vc_flush_done_o <= 1'b0;
    end else begin
      victim_hit_o    <= 1'b0;
      vc_flush_done_o <= 1'b0;
      if (lookup_ok) begin
        victim_hit_o <= lk_any;
        if (lk_any) begin
          hit_idx         <= lk_idx;
          vc_line_o       <= line[lk_idx];
          vc_line_dirty_o <= dirty[lk_idx];
        end
      end
      if (take) valid[hit_idx] <= 1'b0;
      if (ins) begin
        valid[ins_idx] <= 1'b1;
        dirty[ins_idx] <= evict_dirty_i;
        if (ins_adv) rp <= rp + 1'b1;
      end
      case (state)
        VC_IDLE: begin
          if (spill) begin
            state        <= VC_WB;
            vc2mem_req_o <= 1'b1;
            flush_pend   <= vc_flush_i;
          end else if (vc_flush_i) begin
            state    <= VC_FLUSH_SCAN;
            scan_idx <= '0;
          end
        end
        VC_WB: begin
          if (mem2vc_ack_i) begin
            vc2mem_req_o <= 1'b0;
            flush_pend   <= 1'b0;
            if (flush_pend || vc_flush_i) begin
              state    <= VC_FLUSH_SCAN;
              scan_idx <= '0;
            end else begin
              state <= VC_IDLE;
            end
          end else if (vc_flush_i) begin
            flush_pend <= 1'b1;
          end
        end
        VC_FLUSH_SCAN: begin
          valid[scan_idx] <= 1'b0;
          if (scan_hit) begin
            state        <= VC_FLUSH_WB;
            vc2mem_req_o <= 1'b1;
          end else if (scan_idx == LAST_IDX) begin
            state           <= VC_FLUSH_DONE;
            vc_flush_done_o <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        VC_FLUSH_WB: begin
          if (mem2vc_ack_i) begin
            vc2mem_req_o <= 1'b0;
            if (scan_idx == LAST_IDX) begin
              state           <= VC_FLUSH_DONE;
              vc_flush_done_o <= 1'b1;
            end else begin
              state    <= VC_FLUSH_SCAN;
              scan_idx <= scan_idx + 1'b1;
            end
          end
        end
        VC_FLUSH_DONE: begin
          rp    <= '0;
          state <= VC_IDLE;
        end
        default: state <= VC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_victim_cache.sv
// Randomized bench for victim_cache against an index-level reference model.
module tb_victim_cache;
  localparam int N = 4, AW = 28, LW = 128;

  logic          clk = 1'b0, rst;
  logic          lookup_req_i, victim_hit_o, vc_line_dirty_o;
  logic [AW-1:0] lookup_addr_i, evict_addr_i, vc2mem_addr_o;
  logic [LW-1:0] vc_line_o, evict_line_i, vc2mem_line_o;
  logic          write_from_victim_i, write_to_victim_i, evict_dirty_i;
  logic          vc_ready_o, vc2mem_req_o, mem2vc_ack_i, vc_flush_i, vc_flush_done_o;

  always #5 clk = ~clk;

  victim_cache #(.VC_ENTRIES(N), .LINE_ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req_i), .lookup_addr_i(lookup_addr_i),
    .victim_hit_o(victim_hit_o), .vc_line_o(vc_line_o), .vc_line_dirty_o(vc_line_dirty_o),
    .write_from_victim_i(write_from_victim_i), .write_to_victim_i(write_to_victim_i),
    .evict_addr_i(evict_addr_i), .evict_line_i(evict_line_i), .evict_dirty_i(evict_dirty_i),
    .vc_ready_o(vc_ready_o), .vc2mem_req_o(vc2mem_req_o), .vc2mem_addr_o(vc2mem_addr_o),
    .vc2mem_line_o(vc2mem_line_o), .mem2vc_ack_i(mem2vc_ack_i),
    .vc_flush_i(vc_flush_i), .vc_flush_done_o(vc_flush_done_o)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pushing while the block is busy is a protocol violation by the bench itself.
  always @(posedge clk)
    if (!rst && write_to_victim_i) assert (vc_ready_o) else $error("push while not ready");

  // Reference model: entries by slot index plus a round-robin pointer.
  logic          m_valid [N];
  logic          m_dirty [N];
  logic [AW-1:0] m_addr  [N];
  logic [LW-1:0] m_line  [N];
  int            m_rp;

  function automatic int m_find(input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    m_rp = 0;
  endtask

  task automatic m_push(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic d,
                        input int swap_idx, output logic wb, output logic [AW-1:0] wa,
                        output logic [LW-1:0] wl);
    int t;
    wb = 1'b0; wa = '0; wl = '0;
    t = swap_idx;
    if (t < 0) t = m_find(a);
    if (t < 0) for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) t = i;
    if (t < 0) begin
      t = m_rp;
      m_rp = (m_rp + 1) % N;
      if (m_dirty[t]) begin wb = 1'b1; wa = m_addr[t]; wl = m_line[t]; end
    end
    m_valid[t] = 1'b1; m_dirty[t] = d; m_addr[t] = a; m_line[t] = l;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 28'h10 + AW'($urandom_range(0, 11));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_expect(input logic [AW-1:0] wa, input logic [LW-1:0] wl);
    int d;
    chk("wb_req", vc2mem_req_o, 1'b1);
    chk("wb_addr", vc2mem_addr_o, wa);
    chk("wb_line", vc2mem_line_o, wl);
    chk("wb_busy", vc_ready_o, 1'b0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      step();
      chk("wb_hold", vc2mem_req_o, 1'b1);
      chk("wb_stable", vc2mem_addr_o, wa);
      chk("wb_busy_hold", vc_ready_o, 1'b0);
    end
    mem2vc_ack_i = 1'b1; step(); mem2vc_ack_i = 1'b0;
    chk("wb_drop", vc2mem_req_o, 1'b0);
    chk("wb_ready", vc_ready_o, 1'b1);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic d);
    logic wb; logic [AW-1:0] wa; logic [LW-1:0] wl;
    m_push(a, l, d, -1, wb, wa, wl);
    write_to_victim_i = 1'b1; evict_addr_i = a; evict_line_i = l; evict_dirty_i = d;
    step();
    write_to_victim_i = 1'b0;
    if (wb) wb_expect(wa, wl);
    else begin
      chk("push_nowb", vc2mem_req_o, 1'b0);
      chk("push_ready", vc_ready_o, 1'b1);
    end
  endtask

  // mode 0: probe only, 1: probe then take, 2: probe then swap in sa (0 = random)
  task automatic lookup(input logic [AW-1:0] a, input int mode, input logic [AW-1:0] sa_in);
    int h; logic [AW-1:0] sa; logic [LW-1:0] sl; logic sd;
    logic wb; logic [AW-1:0] wa; logic [LW-1:0] wl;
    h = m_find(a);
    lookup_req_i = 1'b1; lookup_addr_i = a;
    step();
    lookup_req_i = 1'b0;
    chk("hit", victim_hit_o, h >= 0);
    if (h >= 0) begin
      chk("hit_line", vc_line_o, m_line[h]);
      chk("hit_dirty", vc_line_dirty_o, m_dirty[h]);
    end
    if (mode == 1) begin
      write_from_victim_i = 1'b1; step(); write_from_victim_i = 1'b0;
      if (h >= 0) m_valid[h] = 1'b0;
      chk("take_hit_drop", victim_hit_o, 1'b0);
    end else if (mode == 2 && h >= 0) begin
      sa = sa_in;
      if (sa == '0) begin
        do sa = rand_addr(); while (m_find(sa) >= 0 && m_find(sa) != h);
      end
      sl = rnd_line(); sd = 1'($urandom_range(0, 1));
      m_valid[h] = 1'b0;
      m_push(sa, sl, sd, h, wb, wa, wl);
      write_from_victim_i = 1'b1; write_to_victim_i = 1'b1;
      evict_addr_i = sa; evict_line_i = sl; evict_dirty_i = sd;
      step();
      write_from_victim_i = 1'b0; write_to_victim_i = 1'b0;
      chk("swap_nowb", vc2mem_req_o, 1'b0);
      chk("swap_ready", vc_ready_o, 1'b1);
    end
  endtask

  task automatic flush(input logic [AW-1:0] probe);
    logic [AW-1:0] qa[$];
    logic [LW-1:0] ql[$];
    int  k = 0, cyc = 0;
    bit  done = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_dirty[i]) begin qa.push_back(m_addr[i]); ql.push_back(m_line[i]); end
    vc_flush_i = 1'b1; step(); vc_flush_i = 1'b0;
    lookup_req_i = 1'b1; lookup_addr_i = probe;
    while (!done && cyc < 200) begin
      cyc++;
      chk("flush_nohit", victim_hit_o, 1'b0);
      if (vc_flush_done_o) done = 1'b1;
      else if (vc2mem_req_o) begin
        if (k < qa.size()) begin
          chk("flush_wb_addr", vc2mem_addr_o, qa[k]);
          chk("flush_wb_line", vc2mem_line_o, ql[k]);
        end else chk("flush_extra_wb", vc2mem_req_o, 1'b0);
        k++;
        mem2vc_ack_i = 1'b1; step(); mem2vc_ack_i = 1'b0;
      end else step();
    end
    lookup_req_i = 1'b0;
    chk("flush_done_seen", done, 1'b1);
    chk("flush_wb_count", k, qa.size());
    step();
    chk("flush_done_pulse", vc_flush_done_o, 1'b0);
    chk("flush_ready", vc_ready_o, 1'b1);
    m_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic wb; logic [AW-1:0] wa; logic [LW-1:0] wl, l1;
    int r;
    rst = 1'b1;
    lookup_req_i = 1'b0; lookup_addr_i = '0; write_from_victim_i = 1'b0;
    write_to_victim_i = 1'b0; evict_addr_i = '0; evict_line_i = '0; evict_dirty_i = 1'b0;
    mem2vc_ack_i = 1'b0; vc_flush_i = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hit", victim_hit_o, 1'b0);
    chk("rst_req", vc2mem_req_o, 1'b0);
    chk("rst_done", vc_flush_done_o, 1'b0);
    chk("rst_line", vc_line_o, '0);
    rst = 1'b0;
    step();
    chk("rst_ready", vc_ready_o, 1'b1);

    // basic hit / miss
    push(28'h10, rnd_line(), 1'b0);
    lookup(28'h10, 0, '0);
    lookup(28'h11, 0, '0);

    // full cache, dirty entry 0 displaced, pointer moves to entry 1
    flush(28'h10);
    push(28'h20, rnd_line(), 1'b1);
    push(28'h21, rnd_line(), 1'b0);
    push(28'h22, rnd_line(), 1'b0);
    push(28'h23, rnd_line(), 1'b0);
    push(28'h24, rnd_line(), 1'b0);
    push(28'h25, rnd_line(), 1'b0);
    lookup(28'h20, 0, '0);
    lookup(28'h21, 0, '0);
    lookup(28'h24, 0, '0);

    // swap: take 0x22 and push 0x30 in the same cycle
    lookup(28'h22, 2, 28'h30);
    lookup(28'h22, 0, '0);
    lookup(28'h30, 0, '0);

    // flush with two dirty and two clean entries
    flush(28'h10);
    push(28'h40, rnd_line(), 1'b1);
    push(28'h41, rnd_line(), 1'b0);
    push(28'h42, rnd_line(), 1'b1);
    push(28'h43, rnd_line(), 1'b0);
    flush(28'h40);
    for (int i = 0; i < 4; i++) lookup(28'h40 + AW'(i), 0, '0);

    // same-address push updates in place and leaves the pointer alone
    push(28'h50, rnd_line(), 1'b0);
    push(28'h50, rnd_line(), 1'b1);
    lookup(28'h50, 0, '0);
    for (int i = 1; i < 5; i++) push(28'h50 + AW'(i), rnd_line(), 1'b0);
    lookup(28'h50, 0, '0);

    // reset in the middle of a write-back
    flush(28'h0);
    for (int i = 0; i < 4; i++) push(28'h60 + AW'(i), rnd_line(), 1'b1);
    l1 = rnd_line();
    m_push(28'h64, l1, 1'b0, -1, wb, wa, wl);
    write_to_victim_i = 1'b1; evict_addr_i = 28'h64; evict_line_i = l1; evict_dirty_i = 1'b0;
    step();
    write_to_victim_i = 1'b0;
    chk("rst_pre_req", vc2mem_req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", vc2mem_req_o, 1'b0);
    chk("rst_async_hit", victim_hit_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_clear();
    for (int i = 0; i < 5; i++) lookup(28'h60 + AW'(i), 0, '0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      push(rand_addr(), rnd_line(), 1'($urandom_range(0, 1)));
      else if (r < 97) lookup(rand_addr(), $urandom_range(0, 2), '0);
      else             flush(rand_addr());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
